shift_arbiter: RTL and testbench

Sequencer and two-way arbiter that shares the single combinational 16-bit shift unit (SLL/SRA/ROR) between two requesters: port 0 (EX stage) and port 1 (secondary client, e.g. address generation). It accepts one request at a time with valid/ready handshakes, drives the external shifter from registered operands, and captures the result. It returns the result on a response channel with requester ID and holds it under backpressure.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_arbiter_if.sv | 47 ++++
 rtl/shift_rr_arb.sv | 32 +++
 rtl/shift_arbiter.sv | 155 +++++++++++++++
 tb/tb_shift_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift-unit sequencer/arbiter:
//   - datapath width and shift-amount width
//   - shifter mode encodings (also the request op encodings)
//   - sequencer state enum
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRA = 2'b01;
    localparam logic [1:0] SH_ROR = 2'b10;
    localparam logic [1:0] SH_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// -----------------------------------------------------------------------------
// shift_arbiter_if
// Request/response bundle of the shift arbiter.
//   req0_* / req1_* : valid/ready request channels (op, data, amt)
//   rsp_*           : valid/ready response channel (id, data, err)
// Modports:
//   master : requesters and result consumer (drive requests, rsp_ready)
//   slave  : the arbiter (drives readys and the response)
// -----------------------------------------------------------------------------
interface shift_arbiter_if;
    import shift_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_data;
    logic [AMT_W-1:0] req0_amt;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_data;
    logic [AMT_W-1:0] req1_amt;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output req0_valid, req0_op, req0_data, req0_amt,
        output req1_valid, req1_op, req1_data, req1_amt,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_data, req0_amt,
        input  req1_valid, req1_op, req1_data, req1_amt,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/shift_rr_arb.sv
// -----------------------------------------------------------------------------
// shift_rr_arb
// Two-way round-robin grant logic (purely combinational).
//   en      in  grant allowed this cycle
//   v0, v1  in  request valids of port 0 / port 1
//   pri     in  port that wins when both are valid
//   gnt     out one-hot grant {port1, port0}; zero when en is low
//   upd     out a grant was issued (pointer must move)
// -----------------------------------------------------------------------------
module shift_rr_arb (
    input  logic       en,
    input  logic       v0,
    input  logic       v1,
    input  logic       pri,
    output logic [1:0] gnt,
    output logic       upd
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            // port 0 wins when alone or when it holds priority
            if (v0 && (!v1 || !pri)) begin
                gnt[0] = 1'b1;
            end else if (v1) begin
                gnt[1] = 1'b1;
            end
        end
        upd = |gnt;
    end

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Sequencer and 2-way arbiter sharing one external combinational 16-bit
// shifter. One request at a time: grant (IDLE or HOLD+rsp_ready), drive the
// shifter from registered operands (SHIFT), capture and hold the result (HOLD).
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : request channels 0/1 and response channel
//   sh_si/sh_sv/sh_mode : registered operand/amount/mode to the shifter
//   sh_so             : shifter result
//   busy              : state is not IDLE
// -----------------------------------------------------------------------------
module shift_arbiter
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    shift_arbiter_if.slave   bus,
    output logic [WIDTH-1:0] sh_si,
    output logic [AMT_W-1:0] sh_sv,
    output logic [1:0]       sh_mode,
    input  logic [WIDTH-1:0] sh_so,
    output logic             busy
);

    state_t           state_q, state_d;
    logic             pri_q, pri_d;
    logic [WIDTH-1:0] sh_si_q, sh_si_d;
    logic [AMT_W-1:0] sh_sv_q, sh_sv_d;
    logic [1:0]       sh_mode_q, sh_mode_d;
    logic             id_q, id_d;
    logic             err_q, err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             arb_en;
    logic [1:0]       gnt;
    logic             upd;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_data;
    logic [AMT_W-1:0] sel_amt;

    // Reset wins over any handshake in the same cycle.
    assign arb_en = !rst && ((state_q == IDLE) ||
                             ((state_q == HOLD) && bus.rsp_ready));

    shift_rr_arb u_arb (
        .en  (arb_en),
        .v0  (bus.req0_valid),
        .v1  (bus.req1_valid),
        .pri (pri_q),
        .gnt (gnt),
        .upd (upd)
    );

    assign sel_op   = gnt[1] ? bus.req1_op   : bus.req0_op;
    assign sel_data = gnt[1] ? bus.req1_data : bus.req0_data;
    assign sel_amt  = gnt[1] ? bus.req1_amt  : bus.req0_amt;

    always_comb begin
        state_d     = state_q;
        pri_d       = pri_q;
        sh_si_d     = sh_si_q;
        sh_sv_d     = sh_sv_q;
        sh_mode_d   = sh_mode_q;
        id_d        = id_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (upd) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                rsp_data_d  = sh_so;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_err_d   = err_q;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = upd ? SHIFT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operand load on any grant; pointer moves to the losing port.
        if (upd) begin
            pri_d   = gnt[0];
            id_d    = gnt[1];
            sh_si_d = sel_data;
            if (sel_op == SH_RSV) begin
                // pass-through: SLL by 0 returns the operand unchanged
                sh_mode_d = SH_SLL;
                sh_sv_d   = '0;
                err_d     = 1'b1;
            end else begin
                sh_mode_d = sel_op;
                sh_sv_d   = sel_amt;
                err_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pri_q       <= 1'b0;
            sh_si_q     <= '0;
            sh_sv_q     <= '0;
            sh_mode_q   <= SH_SLL;
            id_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pri_q       <= pri_d;
            sh_si_q     <= sh_si_d;
            sh_sv_q     <= sh_sv_d;
            sh_mode_q   <= sh_mode_d;
            id_q        <= id_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign sh_si          = sh_si_q;
    assign sh_sv          = sh_sv_q;
    assign sh_mode        = sh_mode_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
// Directed bench for shift_arbiter with a behavioural model of the external
// shared shifter hooked between sh_* and sh_so. Expected results are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] sh_si;
    logic [3:0]  sh_sv;
    logic [1:0]  sh_mode;
    logic [15:0] sh_so;
    logic        busy;

    int ncmp = 0;
    int nerr = 0;

    shift_arbiter_if bus ();

    shift_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sh_si   (sh_si),
        .sh_sv   (sh_sv),
        .sh_mode (sh_mode),
        .sh_so   (sh_so),
        .busy    (busy)
    );

    // External shared shifter.
    function automatic logic [15:0] shifter(input logic [15:0] si,
                                            input logic [3:0] sv,
                                            input logic [1:0] mode);
        logic [31:0] dbl;
        case (mode)
            2'b00:   return si << sv;
            2'b01:   return 16'($signed(si) >>> sv);
            2'b10: begin
                dbl = {si, si} >> sv;
                return dbl[15:0];
            end
            default: return si;
        endcase
    endfunction

    assign sh_so = shifter(sh_si, sh_sv, sh_mode);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, " rsp_id"},    bus.rsp_id,    0);
        chk({tag, " rsp_data"},  bus.rsp_data,  0);
        chk({tag, " rsp_err"},   bus.rsp_err,   0);
        chk({tag, " sh_si"},     sh_si,         0);
        chk({tag, " sh_sv"},     sh_sv,         0);
        chk({tag, " sh_mode"},   sh_mode,       0);
        chk({tag, " busy"},      busy,          0);
    endtask

    // Full single transaction from IDLE with rsp_ready low until HOLD.
    task automatic do_req(input string tag, input logic port, input logic [1:0] op,
                          input logic [15:0] d, input logic [3:0] amt,
                          input logic [15:0] exp, input logic exp_err);
        if (port == 1'b0) begin
            bus.req0_op = op; bus.req0_data = d; bus.req0_amt = amt; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op = op; bus.req1_data = d; bus.req1_amt = amt; bus.req1_valid = 1'b1;
        end
        #1;
        chk({tag, " ready0"}, bus.req0_ready, (port == 1'b0));
        chk({tag, " ready1"}, bus.req1_ready, (port == 1'b1));
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk({tag, " T1 busy"},      busy,          1);
        chk({tag, " T1 rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, " T1 sh_si"},     sh_si,         d);
        chk({tag, " T1 sh_sv"},     sh_sv,         exp_err ? 4'd0 : amt);
        chk({tag, " T1 sh_mode"},   sh_mode,       exp_err ? 2'd0 : op);
        step();
        chk({tag, " T2 rsp_valid"}, bus.rsp_valid, 1);
        chk({tag, " T2 rsp_data"},  bus.rsp_data,  exp);
        chk({tag, " T2 rsp_id"},    bus.rsp_id,    port);
        chk({tag, " T2 rsp_err"},   bus.rsp_err,   exp_err);
        bus.rsp_ready = 1'b1;
        step();
        chk({tag, " done rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, " done busy"},      busy,          0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_data = 16'h0; bus.req0_amt = 4'h0;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_data = 16'h0; bus.req1_amt = 4'h0;
        bus.rsp_ready = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        chk("reset ready0", bus.req0_ready, 0);
        chk("reset ready1", bus.req1_ready, 0);
        rst = 1'b0;

        // Basic ops
        do_req("sra",      1'b0, 2'b01, 16'h8000, 4'd3,  16'hF000, 1'b0);
        do_req("sll",      1'b1, 2'b00, 16'h0001, 4'd15, 16'h8000, 1'b0);
        do_req("ror",      1'b1, 2'b10, 16'h1234, 4'd4,  16'h4123, 1'b0);
        do_req("sra0",     1'b0, 2'b01, 16'h8421, 4'd0,  16'h8421, 1'b0);
        do_req("ror0",     1'b1, 2'b10, 16'hA5C3, 4'd0,  16'hA5C3, 1'b0);
        do_req("sll0",     1'b0, 2'b00, 16'h1357, 4'd0,  16'h1357, 1'b0);
        do_req("reserved", 1'b0, 2'b11, 16'hBEEF, 4'd7,  16'hBEEF, 1'b1);

        // Contention straight after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req0_op = 2'b00; bus.req0_data = 16'h0003; bus.req0_amt = 4'd2; bus.req0_valid = 1'b1;
        bus.req1_op = 2'b01; bus.req1_data = 16'h4000; bus.req1_amt = 4'd1; bus.req1_valid = 1'b1;
        #1;
        chk("cont1 ready0", bus.req0_ready, 1);
        chk("cont1 ready1", bus.req1_ready, 0);
        step();
        bus.req0_valid = 1'b0;
        #1;
        chk("cont1 shift readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
        step();
        chk("cont1 rsp_valid", bus.rsp_valid, 1);
        chk("cont1 rsp_data",  bus.rsp_data,  16'h000C);
        chk("cont1 rsp_id",    bus.rsp_id,    0);
        chk("cont1 hold ready1", bus.req1_ready, 1);
        chk("cont1 hold ready0", bus.req0_ready, 0);
        step();
        bus.req1_valid = 1'b0;
        // second pair presented while port1 is in SHIFT
        bus.req0_op = 2'b10; bus.req0_data = 16'h000F; bus.req0_amt = 4'd1; bus.req0_valid = 1'b1;
        bus.req1_op = 2'b00; bus.req1_data = 16'h00FF; bus.req1_amt = 4'd8; bus.req1_valid = 1'b1;
        #1;
        chk("cont2 shift readys", {bus.req1_ready, bus.req0_ready}, 2'b00);
        step();
        chk("cont2 rsp_data", bus.rsp_data, 16'h2000);
        chk("cont2 rsp_id",   bus.rsp_id,   1);
        chk("cont2 ready0",   bus.req0_ready, 1);
        chk("cont2 ready1",   bus.req1_ready, 0);
        step();
        bus.req0_valid = 1'b0;
        step();
        chk("cont3 rsp_data", bus.rsp_data, 16'h8007);
        chk("cont3 rsp_id",   bus.rsp_id,   0);
        chk("cont3 ready1",   bus.req1_ready, 1);
        chk("cont3 ready0",   bus.req0_ready, 0);
        step();
        bus.req1_valid = 1'b0;
        step();
        chk("cont4 rsp_data", bus.rsp_data, 16'hFF00);
        chk("cont4 rsp_id",   bus.rsp_id,   1);
        chk("cont4 readys",   {bus.req1_ready, bus.req0_ready}, 2'b00);
        step();
        chk("cont4 idle rsp_valid", bus.rsp_valid, 0);
        chk("cont4 idle busy",      busy,          0);
        bus.rsp_ready = 1'b0;

        // Backpressure
        bus.req0_op = 2'b00; bus.req0_data = 16'h0101; bus.req0_amt = 4'd4; bus.req0_valid = 1'b1;
        #1;
        chk("bp ready0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_op = 2'b01; bus.req1_data = 16'h7FF0; bus.req1_amt = 4'd4; bus.req1_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid", bus.rsp_valid, 1);
            chk("bp rsp_data",  bus.rsp_data,  16'h1010);
            chk("bp rsp_id",    bus.rsp_id,    0);
            chk("bp readys",    {bus.req1_ready, bus.req0_ready}, 2'b00);
            chk("bp busy",      busy,          1);
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp release ready1", bus.req1_ready, 1);
        chk("bp release ready0", bus.req0_ready, 0);
        step();
        bus.req1_valid = 1'b0;
        chk("bp shift rsp_valid", bus.rsp_valid, 0);
        step();
        chk("bp next rsp_valid", bus.rsp_valid, 1);
        chk("bp next rsp_data",  bus.rsp_data,  16'h07FF);
        chk("bp next rsp_id",    bus.rsp_id,    1);
        step();
        chk("bp idle rsp_valid", bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;

        // Reset mid-operation (port0 grant moves the pointer to 1 first)
        bus.req0_op = 2'b00; bus.req0_data = 16'h00F0; bus.req0_amt = 4'd4; bus.req0_valid = 1'b1;
        #1;
        chk("rmid ready0", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        chk("rmid shift busy", busy, 1);
        rst = 1'b1;
        step();
        chk_reset_vals("rmid after");
        // request during reset must not be accepted
        bus.req0_op = 2'b00; bus.req0_data = 16'h0003; bus.req0_amt = 4'd1; bus.req0_valid = 1'b1;
        #1;
        chk("rmid rst ready0", bus.req0_ready, 0);
        step();
        chk("rmid rst busy", busy, 0);
        rst = 1'b0;
        bus.req1_op = 2'b01; bus.req1_data = 16'h8000; bus.req1_amt = 4'd15; bus.req1_valid = 1'b1;
        #1;
        chk("rmid post ready0", bus.req0_ready, 1);
        chk("rmid post ready1", bus.req1_ready, 0);
        chk("rmid post rsp_valid", bus.rsp_valid, 0);
        step();
        bus.req0_valid = 1'b0;
        step();
        chk("rmid rsp_valid", bus.rsp_valid, 1);
        chk("rmid rsp_data",  bus.rsp_data,  16'h0006);
        chk("rmid rsp_id",    bus.rsp_id,    0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("rmid ready1", bus.req1_ready, 1);
        step();
        bus.req1_valid = 1'b0;
        step();
        chk("rmid p1 rsp_data", bus.rsp_data, 16'hFFFF);
        chk("rmid p1 rsp_id",   bus.rsp_id,   1);
        step();
        chk("rmid p1 idle", busy, 0);
        bus.rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
